// File: rtl/dotfetch_pipe.sv
// Character-cell fetch stage: one text-RAM read per cell, sideband delayed to
// match RAM latency, fetched word held for the cell, blink phase and cursor hit.
module dotfetch_pipe #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int CHAR_W       = 8,
  parameter int HCTR_W       = 3,
  parameter int VCTR_W       = 3,
  parameter int RAM_LAT      = 1,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                     CLK_108MHz,
  input  logic                     reset,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     de_in,
  input  logic [HCTR_W-1:0]        hctr_in,
  input  logic [VCTR_W-1:0]        vctr_in,
  input  logic [ADDR_W-1:0]        address_in,
  input  logic [ADDR_W-1:0]        cursor_addr,
  input  logic                     cursor_en,
  input  logic [VCTR_W-1:0]        cursor_start,
  input  logic [VCTR_W-1:0]        cursor_end,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     de_out,
  output logic [HCTR_W-1:0]        hctr_out,
  output logic [VCTR_W-1:0]        vctr_out,
  output logic [CHAR_W-1:0]        character_out,
  output logic [DATA_W-CHAR_W-1:0] color_out,
  output logic                     blink_out,
  output logic                     cursor_out,
  output logic [ADDR_W-1:0]        addr,
  output logic                     ena,
  output logic                     wena,
  output logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W-1:0]        rdata
);

  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_ram_lat
    $error("dotfetch_pipe: RAM_LAT must be in 1..4");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
    $error("dotfetch_pipe: BLINK_FRAMES must be in 1..255");
  end

  // Sideband word layout: {cursor, fetch, hsync, vsync, de, hctr, vctr}
  localparam int HC_LO = VCTR_W;
  localparam int DE_B  = HCTR_W + VCTR_W;
  localparam int VS_B  = DE_B + 1;
  localparam int HS_B  = DE_B + 2;
  localparam int FE_B  = DE_B + 3;
  localparam int CU_B  = DE_B + 4;
  localparam int SB_W  = DE_B + 5;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic              fetch;
  logic              cursor_hit;
  logic [SB_W-1:0]   sb_in;
  logic [SB_W-1:0]   dly_q [RAM_LAT+1];
  logic [DATA_W-1:0] word_q, word_d;
  logic              vsync_q;
  logic              vs_rise;
  logic [7:0]        frame_q, frame_d;
  logic              blink_q, blink_d;
  logic              wena_q;
  logic [DATA_W-1:0] wdata_q;

  assign addr  = address_in;
  assign fetch = de_in && (hctr_in == '0);
  assign ena   = fetch;

  // An inverted line range never matches, so no extra start<=end test is needed.
  assign cursor_hit = cursor_en && (address_in == cursor_addr) &&
                      (vctr_in >= cursor_start) && (vctr_in <= cursor_end) && blink_q;

  assign sb_in = {cursor_hit, fetch, hsync_in, vsync_in, de_in, hctr_in, vctr_in};

  always_ff @(posedge CLK_108MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RAM_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= sb_in;
      for (int i = 1; i <= RAM_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // Stage RAM_LAT-1 lines up with the cycle rdata answers that request.
  always_comb begin
    word_d = word_q;
    if (dly_q[RAM_LAT-1][FE_B])      word_d = rdata;
    else if (!dly_q[RAM_LAT-1][DE_B]) word_d = '0;
  end

  assign vs_rise = vsync_in && !vsync_q;

  always_comb begin
    frame_d = frame_q;
    blink_d = blink_q;
    if (vs_rise) begin
      if (frame_q == BLINK_LAST) begin
        frame_d = '0;
        blink_d = !blink_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK_108MHz or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      vsync_q <= 1'b0;
      frame_q <= '0;
      blink_q <= 1'b0;
      wena_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      word_q  <= word_d;
      vsync_q <= vsync_in;
      frame_q <= frame_d;
      blink_q <= blink_d;
      wena_q  <= 1'b0;
      wdata_q <= '0;
    end
  end

  assign hsync_out     = dly_q[RAM_LAT][HS_B];
  assign vsync_out     = dly_q[RAM_LAT][VS_B];
  assign de_out        = dly_q[RAM_LAT][DE_B];
  assign hctr_out      = dly_q[RAM_LAT][DE_B-1:HC_LO];
  assign vctr_out      = dly_q[RAM_LAT][HC_LO-1:0];
  assign cursor_out    = dly_q[RAM_LAT][CU_B];
  assign character_out = word_q[CHAR_W-1:0];
  assign color_out     = word_q[DATA_W-1:CHAR_W];
  assign blink_out     = blink_q;
  assign wena          = wena_q;
  assign wdata         = wdata_q;

endmodule

// File: tb/tb_dotfetch_pipe.sv
// Bench for dotfetch_pipe: two instances (RAM latency 1 and 3) share stimulus and
// are checked against a history-based reference model of the fetch/blink/cursor rules.
module tb_dotfetch_pipe;
  localparam int AW = 16, DW = 16, CW = 8, HW = 3, VW = 3, BF = 2, NH = 4096;
  localparam int TW = 3 + HW + VW;
  localparam int XW = TW + DW + 2 + 1 + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, hs, vs, de, cur_en;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc, cur_s, cur_e;
  logic [AW-1:0] ad, cur_addr;
  logic [DW-1:0] rdata1, rdata3;

  logic hso1, vso1, deo1, bl1, cu1, en1, we1;
  logic hso3, vso3, deo3, bl3, cu3, en3, we3;
  logic [HW-1:0] hco1, hco3;
  logic [VW-1:0] vco1, vco3;
  logic [CW-1:0] ch1, ch3;
  logic [DW-CW-1:0] co1, co3;
  logic [AW-1:0] ad1, ad3;
  logic [DW-1:0] wd1, wd3;

  dotfetch_pipe #(.ADDR_W(AW), .DATA_W(DW), .CHAR_W(CW), .HCTR_W(HW), .VCTR_W(VW),
                  .RAM_LAT(1), .BLINK_FRAMES(BF)) d1 (
    .CLK_108MHz(clk), .reset(rst), .hsync_in(hs), .vsync_in(vs), .de_in(de),
    .hctr_in(hc), .vctr_in(vc), .address_in(ad), .cursor_addr(cur_addr),
    .cursor_en(cur_en), .cursor_start(cur_s), .cursor_end(cur_e),
    .hsync_out(hso1), .vsync_out(vso1), .de_out(deo1), .hctr_out(hco1), .vctr_out(vco1),
    .character_out(ch1), .color_out(co1), .blink_out(bl1), .cursor_out(cu1),
    .addr(ad1), .ena(en1), .wena(we1), .wdata(wd1), .rdata(rdata1));

  dotfetch_pipe #(.ADDR_W(AW), .DATA_W(DW), .CHAR_W(CW), .HCTR_W(HW), .VCTR_W(VW),
                  .RAM_LAT(3), .BLINK_FRAMES(BF)) d3 (
    .CLK_108MHz(clk), .reset(rst), .hsync_in(hs), .vsync_in(vs), .de_in(de),
    .hctr_in(hc), .vctr_in(vc), .address_in(ad), .cursor_addr(cur_addr),
    .cursor_en(cur_en), .cursor_start(cur_s), .cursor_end(cur_e),
    .hsync_out(hso3), .vsync_out(vso3), .de_out(deo3), .hctr_out(hco3), .vctr_out(vco3),
    .character_out(ch3), .color_out(co3), .blink_out(bl3), .cursor_out(cu3),
    .addr(ad3), .ena(en3), .wena(we3), .wdata(wd3), .rdata(rdata3));

  logic [TW-1:0] tim1, tim3;
  logic [DW-1:0] word1, word3;
  assign tim1  = {hso1, vso1, deo1, hco1, vco1};
  assign tim3  = {hso3, vso3, deo3, hco3, vco3};
  assign word1 = {co1, ch1};
  assign word3 = {co3, ch3};

  int n_chk = 0, n_pass = 0;
  int k = 0;            // index of the next rising edge
  int edges = 0;
  logic prev_vs = 1'b0;

  // Per-edge history of what the DUT sampled on that edge
  logic          h_rst [NH];
  logic          h_hs [NH], h_vs [NH], h_de [NH], h_cu [NH], blink_m [NH];
  logic [HW-1:0] h_hc [NH];
  logic [VW-1:0] h_vc [NH];
  logic [AW-1:0] h_ad [NH];

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    if (a == 16'h0100) return 16'h1E41;
    if (a == 16'h0101) return 16'h0742;
    return {a[7:0] ^ 8'hA5, a[15:8] + a[7:0] + 8'h01};
  endfunction

  function automatic logic fe(input int j);
    return h_de[j] && (h_hc[j] == '0);
  endfunction

  // Sample q-L reaches the output after edge q unless a reset hit edges q-L..q.
  function automatic logic valid(input int q, input int L);
    if (q - L < 0) return 1'b0;
    for (int i = q - L; i <= q; i++) if (h_rst[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [TW-1:0] exp_tim(input int q, input int L);
    if (!valid(q, L)) return '0;
    return {h_hs[q-L], h_vs[q-L], h_de[q-L], h_hc[q-L], h_vc[q-L]};
  endfunction

  function automatic logic exp_cur(input int q, input int L);
    return valid(q, L) ? h_cu[q-L] : 1'b0;
  endfunction

  // Word of the latest fetch in the unbroken display-enable run ending at the aligned sample.
  function automatic logic [DW-1:0] exp_word(input int q, input int L);
    for (int p = q; p >= 0; p--) begin
      if (!valid(p, L)) return '0;
      if (fe(p - L)) return mem(h_ad[p-L]);
      if (!h_de[p-L]) return '0;
    end
    return '0;
  endfunction

  function automatic logic [XW-1:0] exp_all(input int q, input int L);
    return {exp_tim(q, L), exp_word(q, L), exp_cur(q, L), blink_m[q], 1'b0, 16'h0000};
  endfunction

  task automatic set_in(input logic d, input logic h, input logic v,
                        input logic [HW-1:0] hcv, input logic [VW-1:0] vcv, input logic [AW-1:0] a);
    de = d; hs = h; vs = v; hc = hcv; vc = vcv; ad = a;
    #1;
  endtask

  task automatic tick();
    int p;
    p = k;
    if (p >= NH) begin
      $display("FAIL history_overflow k=%0d limit=%0d", p, NH);
      $fatal(1);
    end
    rdata1 = (p >= 1 && fe(p - 1)) ? mem(h_ad[p-1]) : DW'($urandom);
    rdata3 = (p >= 3 && fe(p - 3)) ? mem(h_ad[p-3]) : DW'($urandom);
    @(posedge clk);
    h_rst[p] = rst; h_hs[p] = hs; h_vs[p] = vs; h_de[p] = de;
    h_hc[p] = hc; h_vc[p] = vc; h_ad[p] = ad;
    h_cu[p] = cur_en && (ad == cur_addr) && (vc >= cur_s) && (vc <= cur_e) &&
              ((p > 0) ? blink_m[p-1] : 1'b0);
    if (rst) begin
      edges = 0; prev_vs = 1'b0;
    end else begin
      if (vs && !prev_vs) edges++;
      prev_vs = vs;
    end
    blink_m[p] = ((edges / BF) % 2) == 1;
    k++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cur_en = 1'b0; cur_addr = '0; cur_s = '0; cur_e = '0;
    set_in(1'b1, 1'b1, 1'b1, '0, 3'd5, 16'h1234);
    repeat (3) tick();
    n_chk++; if ({tim1, word1, cu1, bl1} !== '0) $display("FAIL reset_out1 got=%h exp=0", {tim1, word1, cu1, bl1}); else n_pass++;
    n_chk++; if ({tim3, word3, cu3, bl3} !== '0) $display("FAIL reset_out3 got=%h exp=0", {tim3, word3, cu3, bl3}); else n_pass++;
    n_chk++; if ({we1, wd1, we3, wd3} !== '0) $display("FAIL reset_wr got=%h exp=0", {we1, wd1, we3, wd3}); else n_pass++;
    n_chk++; if ({en1, ad1} !== {1'b1, 16'h1234}) $display("FAIL reset_req got=%h exp=%h", {en1, ad1}, {1'b1, 16'h1234}); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_fetch_stream();
    int j0, q;
    logic d;
    logic [HW-1:0] h;
    logic [AW-1:0] a;
    j0 = k; a = '0;
    for (int t = 0; t < 56; t++) begin
      d = (t < 48); h = HW'(t % 8);
      if (t % 8 == 0) a = (t == 0) ? 16'h0100 : (t == 8) ? 16'h0101 : AW'($urandom);
      set_in(d, 1'(t % 8 > 5), 1'b0, h, 3'd2, a);
      n_chk++;
      if ({en1, en3, ad1, ad3} !== {d && h == 0, d && h == 0, a, a})
        $display("FAIL stream_req t=%0d got=%h exp=%h", t, {en1, en3, ad1, ad3}, {d && h == 0, d && h == 0, a, a});
      else n_pass++;
      tick(); q = k - 1;
      n_chk++; if (tim1 !== exp_tim(q, 1)) $display("FAIL stream_tim1 k=%0d got=%h exp=%h", q, tim1, exp_tim(q, 1)); else n_pass++;
      n_chk++; if (tim3 !== exp_tim(q, 3)) $display("FAIL stream_tim3 k=%0d got=%h exp=%h", q, tim3, exp_tim(q, 3)); else n_pass++;
      n_chk++; if (word1 !== exp_word(q, 1)) $display("FAIL stream_word1 k=%0d got=%h exp=%h", q, word1, exp_word(q, 1)); else n_pass++;
      n_chk++; if (word3 !== exp_word(q, 3)) $display("FAIL stream_word3 k=%0d got=%h exp=%h", q, word3, exp_word(q, 3)); else n_pass++;
      if (q == j0 + 1) begin
        n_chk++; if ({co1, ch1} !== 16'h1E41) $display("FAIL first_word_lat1 got=%h exp=1e41", {co1, ch1}); else n_pass++;
      end
      if (q == j0 + 3) begin
        n_chk++; if ({deo3, co3, ch3} !== {1'b1, 16'h1E41}) $display("FAIL first_word_lat3 got=%h exp=11e41", {deo3, co3, ch3}); else n_pass++;
      end
      if (q == j0 + 10) begin
        n_chk++; if (word3 !== 16'h1E41) $display("FAIL boundary_hold_lat3 got=%h exp=1e41", word3); else n_pass++;
      end
      if (q == j0 + 11) begin
        n_chk++; if (word3 !== 16'h0742) $display("FAIL boundary_next_lat3 got=%h exp=0742", word3); else n_pass++;
      end
    end
  endtask

  task automatic test_mid_cell_de();
    int q, start;
    logic d;
    logic [HW-1:0] h;
    logic [AW-1:0] a;
    start = k + 6;
    for (int t = 0; t < 25; t++) begin
      d = (t >= 6 && t < 17);
      h = (t < 6) ? HW'(t) : HW'(t - 1);
      a = (t < 9) ? 16'h0222 : 16'h0333;
      set_in(d, 1'b0, 1'b0, h, 3'd4, a);
      n_chk++; if ({en1, en3} !== {2{d && h == 0}}) $display("FAIL midcell_ena t=%0d got=%b exp=%b", t, {en1, en3}, {2{d && h == 0}}); else n_pass++;
      tick(); q = k - 1;
      n_chk++; if (word1 !== exp_word(q, 1)) $display("FAIL midcell_word1 k=%0d got=%h exp=%h", q, word1, exp_word(q, 1)); else n_pass++;
      n_chk++; if (word3 !== exp_word(q, 3)) $display("FAIL midcell_word3 k=%0d got=%h exp=%h", q, word3, exp_word(q, 3)); else n_pass++;
      if (q == start + 1) begin
        n_chk++; if ({deo1, word1} !== {1'b1, 16'h0000}) $display("FAIL midcell_nofetch got=%h exp=10000", {deo1, word1}); else n_pass++;
      end
    end
  endtask

  task automatic test_blink();
    int q;
    logic b1, b3;
    logic [4:0] tog1, tog3;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) tick();
    rst = 1'b0;
    tog1 = '0; tog3 = '0; b1 = bl1; b3 = bl3;
    for (int pl = 0; pl < 5; pl++) begin
      for (int c = 0; c < 6; c++) begin
        set_in(1'($urandom), 1'b0, c < 2, HW'(c), '0, '0);
        tick(); q = k - 1;
        n_chk++; if ({bl1, bl3} !== {2{blink_m[q]}}) $display("FAIL blink k=%0d got=%b exp=%b", q, {bl1, bl3}, {2{blink_m[q]}}); else n_pass++;
        if (bl1 !== b1) tog1[pl] = 1'b1;
        if (bl3 !== b3) tog3[pl] = 1'b1;
        b1 = bl1; b3 = bl3;
      end
    end
    n_chk++; if ({tog1, tog3} !== {5'b01010, 5'b01010}) $display("FAIL blink_toggle_pulses got=%b exp=%b", {tog1, tog3}, {5'b01010, 5'b01010}); else n_pass++;
  endtask

  task automatic test_cursor();
    int q, hi1, hi3;
    logic [AW-1:0] a;
    for (int c = 0; c < 6; c++) begin
      set_in(1'b0, 1'b0, c < 2, '0, '0, '0);
      tick();
    end
    n_chk++; if ({bl1, bl3} !== 2'b11) $display("FAIL cursor_blink_phase got=%b exp=11", {bl1, bl3}); else n_pass++;
    cur_en = 1'b1; cur_addr = 16'h0100;
    for (int cfg = 0; cfg < 3; cfg++) begin
      cur_s = (cfg == 0) ? 3'd6 : (cfg == 1) ? 3'd7 : VW'($urandom);
      cur_e = (cfg == 0) ? 3'd7 : (cfg == 1) ? 3'd6 : VW'($urandom);
      hi1 = 0; hi3 = 0;
      for (int t = 0; t < 196; t++) begin
        a = 16'h00FF + AW'((t / 8) % 3);
        set_in(t < 192, 1'b0, 1'b0, HW'(t % 8), VW'(t / 24), a);
        tick(); q = k - 1;
        n_chk++; if (cu1 !== exp_cur(q, 1)) $display("FAIL cursor1 k=%0d got=%b exp=%b", q, cu1, exp_cur(q, 1)); else n_pass++;
        n_chk++; if (cu3 !== exp_cur(q, 3)) $display("FAIL cursor3 k=%0d got=%b exp=%b", q, cu3, exp_cur(q, 3)); else n_pass++;
        if (cu1 === 1'b1) hi1++;
        if (cu3 === 1'b1) hi3++;
      end
      if (cfg == 0) begin
        n_chk++; if (hi1 != 16 || hi3 != 16) $display("FAIL cursor_lines67 got=%0d/%0d exp=16/16", hi1, hi3); else n_pass++;
      end
      if (cfg == 1) begin
        n_chk++; if (hi1 != 0 || hi3 != 0) $display("FAIL cursor_inverted got=%0d/%0d exp=0/0", hi1, hi3); else n_pass++;
      end
    end
    cur_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int q, jn;
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 16'h0101); tick();
    set_in(1'b1, 1'b0, 1'b0, 3'd1, 3'd3, 16'h0101); tick();
    rst = 1'b1;
    #1;
    n_chk++; if ({tim1, word1, cu1, bl1} !== '0) $display("FAIL midreset_out1 got=%h exp=0", {tim1, word1, cu1, bl1}); else n_pass++;
    n_chk++; if ({tim3, word3, cu3, bl3} !== '0) $display("FAIL midreset_out3 got=%h exp=0", {tim3, word3, cu3, bl3}); else n_pass++;
    set_in(1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 16'h0101); tick();
    set_in(1'b1, 1'b0, 1'b0, 3'd3, 3'd3, 16'h0101); tick();
    rst = 1'b0;
    jn = k + 4;
    for (int t = 4; t < 20; t++) begin
      set_in(t < 16, 1'b0, 1'b0, HW'(t % 8), 3'd3, (t < 8) ? 16'h0101 : 16'h0100);
      tick(); q = k - 1;
      n_chk++; if (word1 !== exp_word(q, 1)) $display("FAIL postreset_word1 k=%0d got=%h exp=%h", q, word1, exp_word(q, 1)); else n_pass++;
      n_chk++; if (word3 !== exp_word(q, 3)) $display("FAIL postreset_word3 k=%0d got=%h exp=%h", q, word3, exp_word(q, 3)); else n_pass++;
      n_chk++; if ({we1, wd1, we3, wd3} !== '0) $display("FAIL postreset_wr got=%h exp=0", {we1, wd1, we3, wd3}); else n_pass++;
      if (q - 3 < jn) begin
        n_chk++; if (word3 !== '0) $display("FAIL stale_fetch_lat3 k=%0d got=%h exp=0", q, word3); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int q;
    logic d, vsv, fen;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [AW-1:0] a;
    d = 1'b1; vsv = 1'b0; h = '0; v = '0; a = 16'h0100;
    for (int t = 0; t < 1500; t++) begin
      if (t % 250 == 0) begin
        cur_en = 1'($urandom); cur_addr = 16'h0100 + AW'($urandom_range(0, 2));
        cur_s = VW'($urandom); cur_e = VW'($urandom);
      end
      if ($urandom_range(0, 19) == 0) d = !d;
      if ($urandom_range(0, 15) == 0) h = HW'($urandom); else h = h + HW'(1);
      if (h == 0) begin
        a = 16'h0100 + AW'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) v = v + VW'(1);
      end
      if ($urandom_range(0, 29) == 0) vsv = !vsv;
      rst = ($urandom_range(0, 299) == 0);
      set_in(d, 1'($urandom), vsv, h, v, a);
      fen = d && (h == 0);
      n_chk++; if ({en1, en3, ad1, ad3} !== {fen, fen, a, a}) $display("FAIL rand_req t=%0d got=%h exp=%h", t, {en1, en3, ad1, ad3}, {fen, fen, a, a}); else n_pass++;
      tick(); q = k - 1;
      n_chk++; if ({tim1, word1, cu1, bl1, we1, wd1} !== exp_all(q, 1)) $display("FAIL rand_lat1 k=%0d got=%h exp=%h", q, {tim1, word1, cu1, bl1, we1, wd1}, exp_all(q, 1)); else n_pass++;
      n_chk++; if ({tim3, word3, cu3, bl3, we3, wd3} !== exp_all(q, 3)) $display("FAIL rand_lat3 k=%0d got=%h exp=%h", q, {tim3, word3, cu3, bl3, we3, wd3}, exp_all(q, 3)); else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout k=%0d", k);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; hc = '0; vc = '0; ad = '0;
    cur_en = 1'b0; cur_addr = '0; cur_s = '0; cur_e = '0; rdata1 = '0; rdata3 = '0;
    @(negedge clk);
    test_reset();
    test_fetch_stream();
    test_mid_cell_de();
    test_blink();
    test_cursor();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dotfetch_pipe.md
Name: dotfetch_pipe

Overview:
Parametrised fetch stage for the character-mode display pipeline. It issues one text-RAM read per character cell, not one per pixel, and tolerates a configurable RAM read latency. It delays all sideband timing signals to match that latency, and holds the fetched character/attribute word for the whole cell. It also generates a frame-based blink phase and a cursor-hit flag aligned with the output pixel. It sits between the address generator and the glyph/colour render stage.

Parameters:
ADDR_W, 16, text-RAM address width
DATA_W, 16, RAM word width; low CHAR_W bits are the character code, remaining upper bits are the attribute
CHAR_W, 8, character code width (DATA_W-CHAR_W = attribute width)
HCTR_W, 3, horizontal in-cell pixel counter width
VCTR_W, 3, vertical in-cell line counter width
RAM_LAT, 1, RAM read latency in cycles; legal 1..4, anything else is an elaboration error
BLINK_FRAMES, 16, frames per blink half-period; legal 1..255

Ports:
CLK_108MHz  in  1  pixel clock
reset  in  1  asynchronous active-high reset
hsync_in / vsync_in / de_in  in  1 each  timing inputs
hctr_in  in  HCTR_W  pixel within cell
vctr_in  in  VCTR_W  line within cell
address_in  in  ADDR_W  character address of current cell
cursor_addr  in  ADDR_W  cursor cell address
cursor_en  in  1  cursor enable
cursor_start / cursor_end  in  VCTR_W each  cursor line range, inclusive
hsync_out / vsync_out / de_out  out  1 each  delayed timing
hctr_out / vctr_out  out  HCTR_W / VCTR_W  delayed counters
character_out  out  CHAR_W  fetched character code
color_out  out  DATA_W-CHAR_W  fetched attribute
blink_out  out  1  blink phase
cursor_out  out  1  cursor hit, pixel-aligned
addr  out  ADDR_W  RAM address
ena  out  1  RAM read enable
wena  out  1  RAM write enable, constant 0
wdata  out  DATA_W  RAM write data, constant 0
rdata  in  DATA_W  RAM read data

Behaviour:
- One clock domain only. Reset is asynchronous and active-high; all registers clear immediately on reset.
- Reset values: all outputs 0, blink_out 0, all delay stages 0, frame counter 0.
- Fetch request (combinational): addr = address_in; ena = de_in AND (hctr_in == 0).
- Timing of a request issued in cycle n:
  - rdata is valid in cycle n+RAM_LAT.
  - The hold register loads rdata at the end of cycle n+RAM_LAT.
- Total latency is RAM_LAT+1 cycles:
  - hsync, vsync, de, hctr and vctr are delayed by RAM_LAT+1 register stages, so values presented in cycle n appear on the outputs in cycle n+RAM_LAT+1.
  - A fetch-valid flag (equal to ena) travels the same delay line.
  - character_out/color_out show the fetched word from cycle n+RAM_LAT+1 onward.
- Hold-register update rule, priority order:
  1. Delayed fetch-valid flag at stage RAM_LAT is high: load rdata.
  2. Otherwise, delayed de at stage RAM_LAT is low: clear to 0.
  3. Otherwise: hold.
- Mid-cell de rise: if de_in rises with hctr_in != 0, no fetch occurs. Outputs stay 0 until the next hctr_in == 0 cell.
- Counter wrap: hctr_in wrapping to 0 always starts a new fetch when de_in is high. No fetch is issued on any other hctr value.
- Cursor:
  - cursor_hit = cursor_en AND address_in == cursor_addr AND cursor_start <= vctr_in <= cursor_end AND blink phase 1.
  - cursor_hit is computed on input and delayed RAM_LAT+1 stages, then driven to cursor_out.
  - If cursor_start > cursor_end, cursor_hit is never asserted.
- Blink:
  - An 8-bit frame counter increments on each rising edge of vsync_in (detected with a registered copy of vsync_in).
  - When the counter reaches BLINK_FRAMES-1, it clears and blink_out toggles on the same edge.
- wena and wdata are registered constants, 0 in and out of reset.
- Reset during operation: pending fetches are discarded and the delay line is flushed. The first valid output follows the first new fetch, RAM_LAT+1 cycles after it is issued.

Test Plan:
- RAM_LAT=1, de_in high, hctr_in counting 0..7 with address_in=0x0100, RAM model returning 0x1E41 -> ena high only on hctr_in=0; from 2 cycles after that, character_out=0x41 and color_out=0x1E for all 8 pixels of the cell; hsync/vsync/de/hctr/vctr outputs are the inputs delayed by 2 cycles.
- RAM_LAT=3, same stimulus -> timing outputs delayed 4 cycles; data appears on the cycle de_out rises for that cell; no glitch at the cell boundary into a cell returning 0x0742.
- de_in rises with hctr_in=5 -> ena stays 0, character_out=0 until the next hctr_in=0, then loads the fetched word.
- BLINK_FRAMES=2, 5 vsync_in pulses -> blink_out toggles on the 2nd and 4th rising edges only.
- cursor_en=1, cursor_addr=0x0100, cursor_start=6, cursor_end=7, blink phase 1 -> cursor_out high only on vctr_out=6 and 7 of cell 0x0100; with cursor_start=7, cursor_end=6 it is never high.
- Assert reset mid-line with a fetch in flight -> all outputs 0 immediately; after release the old fetch does not appear; wena=0 and wdata=0 throughout.
